// File: rtl/bus_data_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_data_memory_pkg
//  Description : Shared constants, scrub FSM state type and the saturating
//                event-counter helper for the data-memory bus target.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_data_memory_pkg;

    // Default SRAM window depth (0x40..0xBF)
    localparam int MEM_DEPTH      = 128;

    // Status register bit layout: {proto_err, oob_err, evt_cnt[5:0]}
    localparam int STAT_PROTO_BIT = 7;
    localparam int STAT_OOB_BIT   = 6;
    localparam int STAT_CNT_MSB   = 5;

    // Scrub FSM encodings
    typedef enum logic [0:0] {
        SCRUB_STATE_IDLE  = 1'b0,
        SCRUB_STATE_SCRUB = 1'b1
    } scrub_state_t;

    // Event counter increment that sticks at all-ones instead of wrapping
    function automatic logic [STAT_CNT_MSB:0] sat_inc(input logic [STAT_CNT_MSB:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_data_memory_array.sv
`default_nettype none
// ============================================================================
//  Module      : bus_mem_array
//  Description : Single-port SRAM array, synchronous write, asynchronous read.
//                Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_mem_array
    import bus_data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [IDX_WIDTH-1:0]  i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_we,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write commits on the same edge the strobe is sampled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/bus_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : bus_data_memory
//  Description : Data-memory bus target. Decodes the SRAM window and the
//                status register, drives bus_data only on legal reads, and
//                flags/counts protocol and out-of-window violations.
//                Optional feature macro: MEM_SCRUB_EN (zero-fill SRAM after
//                reset, busy high while filling).
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_data_memory
    import bus_data_memory_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_START_ADDR = 'h40,
    parameter int MEM_STOP_ADDR  = 'hBF,
    parameter int STAT_ADDR      = 'hC0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic                  mem_cs,
    input  logic                  mem_we,
    input  logic                  mem_oe,
    output logic                  busy,
    output logic                  err
);

    localparam int c_depth = MEM_STOP_ADDR - MEM_START_ADDR + 1;
    localparam int c_idx_w = $clog2(c_depth);

    logic                       w_busy;
    logic                       w_hit;
    logic                       w_stat;
    logic [c_idx_w-1:0]         w_idx;
    logic                       w_legal;
    logic                       w_wr;
    logic                       w_rd;
    logic                       w_srd;
    logic                       w_clear;
    logic                       w_proto_evt;
    logic                       w_oob_evt;
    logic [c_idx_w-1:0]         w_arr_addr;
    logic [DATA_WIDTH-1:0]      w_arr_wdata;
    logic                       w_arr_we;
    logic [DATA_WIDTH-1:0]      w_arr_rdata;
    logic [DATA_WIDTH-1:0]      w_status;

    logic                       r_proto_err;
    logic                       r_oob_err;
    logic [STAT_CNT_MSB:0]      r_evt_cnt;

    // Address decode: the range compare on the full address also rejects any
    // access with a non-zero upper byte
    assign w_hit  = mem_cs && (bus_addr >= ADDR_WIDTH'(MEM_START_ADDR))
                           && (bus_addr <= ADDR_WIDTH'(MEM_STOP_ADDR));
    assign w_stat = mem_cs && (bus_addr == ADDR_WIDTH'(STAT_ADDR));
    assign w_idx  = c_idx_w'(bus_addr - ADDR_WIDTH'(MEM_START_ADDR));

    // Access qualification; reset and scrub suppress every bus action
    assign w_legal     = !reset && !w_busy;
    assign w_wr        = w_legal && w_hit  && mem_we && !mem_oe;
    assign w_rd        = w_legal && w_hit  && mem_oe && !mem_we;
    assign w_srd       = w_legal && w_stat && mem_oe && !mem_we;
    assign w_clear     = w_legal && w_stat && mem_we && !mem_oe;
    assign w_proto_evt = !reset && mem_cs && (w_busy || (mem_we && mem_oe));
    assign w_oob_evt   = w_legal && mem_cs && !w_hit && !w_stat && (mem_we ^ mem_oe);

`ifdef MEM_SCRUB_EN
    scrub_state_t        r_state;
    logic [c_idx_w-1:0]  r_scrub_idx;
    logic                r_busy;

    // Scrub FSM: zero every SRAM word once after each reset, then idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SCRUB_STATE_SCRUB;
            r_scrub_idx <= '0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                SCRUB_STATE_SCRUB: begin
                    r_scrub_idx <= r_scrub_idx + 1'b1;
                    if (r_scrub_idx == c_idx_w'(c_depth - 1)) begin
                        r_state <= SCRUB_STATE_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= SCRUB_STATE_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_busy      = r_busy;
    assign w_arr_addr  = w_busy ? r_scrub_idx : w_idx;
    assign w_arr_wdata = w_busy ? '0 : bus_data;
    assign w_arr_we    = w_busy ? 1'b1 : w_wr;
`else
    assign w_busy      = 1'b0;
    assign w_arr_addr  = w_idx;
    assign w_arr_wdata = bus_data;
    assign w_arr_we    = w_wr;
`endif

    assign busy = w_busy;

    bus_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (c_depth),
        .IDX_WIDTH  (c_idx_w)
    ) u_array (
        .clk     (clk),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .i_we    (w_arr_we),
        .o_rdata (w_arr_rdata)
    );

    // Sticky error flags and saturating event counter; at most one event per
    // cycle, and a clear never coincides with an event
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_proto_err <= 1'b0;
            r_oob_err   <= 1'b0;
            r_evt_cnt   <= '0;
        end else if (w_proto_evt) begin
            r_proto_err <= 1'b1;
            r_evt_cnt   <= sat_inc(r_evt_cnt);
        end else if (w_oob_evt) begin
            r_oob_err   <= 1'b1;
            r_evt_cnt   <= sat_inc(r_evt_cnt);
        end
    end

    // Status word layout for memory-mapped reads
    always_comb begin
        w_status                       = '0;
        w_status[STAT_PROTO_BIT]       = r_proto_err;
        w_status[STAT_OOB_BIT]         = r_oob_err;
        w_status[STAT_CNT_MSB:0]       = r_evt_cnt;
    end

    assign err      = r_proto_err | r_oob_err;
    assign bus_data = w_rd  ? w_arr_rdata :
                      w_srd ? w_status    : 'z;

endmodule
`default_nettype wire

// File: tb/tb_bus_data_memory.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bus_data_memory
//  Description : Randomised self-checking bench for bus_data_memory with a
//                behavioural model of the SRAM window and status register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_addr;
    wire  [7:0]  bus_data;
    logic        mem_cs;
    logic        mem_we;
    logic        mem_oe;
    logic        busy;
    logic        err;

    // Bench-side bus master driver (write data, or a keeper value whenever
    // the target is expected to be silent)
    logic        tb_drv;
    logic [7:0]  tb_val;
    assign bus_data = tb_drv ? tb_val : 8'hzz;

    always #5 clk = ~clk;

    bus_data_memory dut (
        .clk      (clk),
        .reset    (reset),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_oe   (mem_oe),
        .busy     (busy),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [7:0] m_mem [256];
    bit         m_val [256];
    bit         m_proto;
    bit         m_oob;
    int         m_cnt;
    int         scrub_left;

    function automatic logic [7:0] m_status();
        return {m_proto, m_oob, 6'(m_cnt)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic m_event(input bit proto);
        if (proto) m_proto = 1'b1;
        else       m_oob   = 1'b1;
        if (m_cnt < 63) m_cnt++;
    endtask

    // One bus cycle: drive at negedge, compare mid-cycle, advance model at posedge
    task automatic bus_cycle(input bit cs, input bit we, input bit oe,
                             input logic [15:0] addr, input logic [7:0] wd,
                             output logic [7:0] seen);
        bit         hit, stat, mbusy, dut_drives, known;
        logic [7:0] exp;
        @(negedge clk);
        mbusy = (scrub_left > 0);
        hit   = cs && (addr >= 16'h0040) && (addr <= 16'h00BF);
        stat  = cs && (addr == 16'h00C0);
        known = 1'b1;
        dut_drives = 1'b0;
        exp   = we ? wd : 8'h00;
        if (!mbusy && oe && !we && hit) begin
            dut_drives = 1'b1;
            exp        = m_mem[addr[7:0]];
            known      = m_val[addr[7:0]];
        end else if (!mbusy && oe && !we && stat) begin
            dut_drives = 1'b1;
            exp        = m_status();
        end
        mem_cs   = cs;
        mem_we   = we;
        mem_oe   = oe;
        bus_addr = addr;
        tb_drv   = !dut_drives;
        tb_val   = we ? wd : 8'h00;
        #2;
        seen = bus_data;
        if (known) chk("bus_data", {8'h00, bus_data}, {8'h00, exp});
        chk("err",  {15'h0, err},  {15'h0, (m_proto | m_oob)});
        chk("busy", {15'h0, busy}, {15'h0, mbusy});
        @(posedge clk);
        if (cs && (mbusy || (we && oe)))              m_event(1'b1);
        else if (cs && !hit && !stat && (we || oe))   m_event(1'b0);
        else if (stat && we)                          begin m_proto = 0; m_oob = 0; m_cnt = 0; end
        else if (hit && we) begin
            m_mem[addr[7:0]] = wd;
            m_val[addr[7:0]] = 1'b1;
        end
        if (scrub_left > 0) scrub_left--;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        mem_cs = 1'b0;
        mem_we = 1'b0;
        mem_oe = 1'b0;
        tb_drv = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        m_proto = 0;
        m_oob   = 0;
        m_cnt   = 0;
`ifdef MEM_SCRUB_EN
        scrub_left = 128;
        for (int i = 'h40; i <= 'hBF; i++) begin
            m_mem[i] = 8'h00;
            m_val[i] = 1'b1;
        end
`endif
    endtask

    task automatic idle(input int n);
        logic [7:0] s;
        for (int i = 0; i < n; i++) bus_cycle(0, 0, 0, 16'h0000, 8'h00, s);
    endtask

    task automatic wait_scrub(output int n);
        logic [7:0] s;
        n = 0;
        #1;
        while (busy && n < 300) begin
            bus_cycle(0, 0, 0, 16'h0000, 8'h00, s);
            n++;
            #1;
        end
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return 16'h0040 + 16'($urandom_range(0, 127));
            6:                return 16'h00C0;
            7:                return 16'($urandom_range(0, 63));
            8:                return 16'h00C1 + 16'($urandom_range(0, 62));
            default:          return {8'($urandom_range(1, 255)), 8'($urandom_range(0, 255))};
        endcase
    endfunction

    initial begin
        logic [7:0]  s;
        logic [15:0] a;
        logic [7:0]  d;
        int          n;

        for (int i = 0; i < 256; i++) begin
            m_mem[i] = 8'h00;
            m_val[i] = 1'b0;
        end
        scrub_left = 0;
        reset = 1'b1; mem_cs = 0; mem_we = 0; mem_oe = 0; bus_addr = '0;
        tb_drv = 1'b0; tb_val = '0;
        do_reset();

`ifdef MEM_SCRUB_EN
        // Restart mid-scrub, then check full scrub length and zeroed window
        idle(60);
        bus_cycle(1, 0, 1, 16'h0060, 8'h00, s);
        chk("busy_read_proto", {8'h00, m_status()}, 16'h0081);
        do_reset();
        wait_scrub(n);
        chk("scrub_len", 16'(n), 16'd128);
        bus_cycle(1, 0, 1, 16'h0077, 8'h00, s);
        chk("scrub_zero", {8'h00, s}, 16'h0000);
`endif

        // Reset state
        bus_cycle(1, 0, 1, 16'h00C0, 8'h00, s);
        chk("rst_status", {8'h00, s}, 16'h0000);

        // Write then read next cycle
        bus_cycle(1, 1, 0, 16'h0040, 8'h5A, s);
        bus_cycle(1, 0, 1, 16'h0040, 8'h00, s);
        chk("rd_0x40", {8'h00, s}, 16'h005A);

        // Protocol error leaves memory untouched
        bus_cycle(1, 1, 0, 16'h0050, 8'h33, s);
        bus_cycle(1, 1, 1, 16'h0050, 8'h11, s);
        bus_cycle(1, 0, 1, 16'h0050, 8'h00, s);
        chk("proto_nowrite", {8'h00, s}, 16'h0033);
        bus_cycle(1, 0, 1, 16'h00C0, 8'h00, s);
        chk("proto_status", {8'h00, s}, 16'h0081);

        // Out-of-window accesses, then clear
        bus_cycle(1, 1, 0, 16'h00C0, 8'hFF, s);
        bus_cycle(1, 0, 1, 16'h0020, 8'h00, s);
        bus_cycle(1, 1, 0, 16'h00C5, 8'h99, s);
        bus_cycle(1, 0, 1, 16'h00C0, 8'h00, s);
        chk("oob_status", {8'h00, s}, 16'h0042);
        #1 chk("err_set", {15'h0, err}, 16'h0001);
        bus_cycle(1, 1, 0, 16'h00C0, 8'h00, s);
        bus_cycle(1, 0, 1, 16'h00C0, 8'h00, s);
        chk("clr_status", {8'h00, s}, 16'h0000);
        #1 chk("err_clr", {15'h0, err}, 16'h0000);

        // Counter saturation
        for (int i = 0; i < 70; i++) bus_cycle(1, 1, 1, rand_addr(), 8'($urandom_range(0, 255)), s);
        bus_cycle(1, 0, 1, 16'h00C0, 8'h00, s);
        chk("sat_status", {8'h00, s}, 16'h00BF);

        // Stack pattern at the window top
        bus_cycle(1, 1, 0, 16'h00BF, 8'h07, s);
        bus_cycle(1, 1, 0, 16'h00BE, 8'h00, s);
        bus_cycle(1, 0, 1, 16'h00BE, 8'h00, s);
        chk("stack_be", {8'h00, s}, 16'h0000);
        bus_cycle(1, 0, 1, 16'h00BF, 8'h00, s);
        chk("stack_bf", {8'h00, s}, 16'h0007);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            a = rand_addr();
            d = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 15))
                0, 1, 2, 3, 4, 5:        bus_cycle(1, 1, 0, a, d, s);
                6, 7, 8, 9, 10, 11:      bus_cycle(1, 0, 1, a, d, s);
                12:                      bus_cycle(1, 1, 1, a, d, s);
                13:                      bus_cycle(0, 0, 0, a, d, s);
                14:                      bus_cycle(1, 0, 0, a, d, s);
                default:                 bus_cycle(0, 1, 0, a, d, s);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
